fully_assoc_cache: RTL and testbench

- Fully associative, read-only cache in front of a fixed 256-byte backing ROM; NUM_LINES ways, true-LRU replacement.
- Every clock, the block looks up `addr`, returns the byte on `out` and flags hit or miss.
- Keeps saturating hit and miss counters for performance monitoring.
- Sits between an 8-bit address source and a data consumer.

---
 rtl/fully_assoc_cache.sv | 125 ++++++++++++
 tb/tb_fully_assoc_cache.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fully_assoc_cache.sv
// Fully associative, read-only cache over a combinational ROM (mem(a) = ~a).
// One access per clock, true-LRU replacement, saturating hit/miss counters.
module fully_assoc_cache #(
  parameter int NUM_LINES = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] out,
  output logic              hit,
  output logic [7:0]        hit_cnt,
  output logic [7:0]        miss_cnt
);

  localparam int IDX_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam logic [IDX_W-1:0] LRU_AGE = IDX_W'(NUM_LINES - 1);

  logic              valid_q [NUM_LINES];
  logic              valid_d [NUM_LINES];
  logic [ADDR_W-1:0] tag_q   [NUM_LINES];
  logic [ADDR_W-1:0] tag_d   [NUM_LINES];
  logic [DATA_W-1:0] data_q  [NUM_LINES];
  logic [DATA_W-1:0] data_d  [NUM_LINES];
  logic [IDX_W-1:0]  age_q   [NUM_LINES];
  logic [IDX_W-1:0]  age_d   [NUM_LINES];

  logic [DATA_W-1:0] out_q, out_d;
  logic              hit_q, hit_d;
  logic [7:0]        hit_cnt_q, hit_cnt_d;
  logic [7:0]        miss_cnt_q, miss_cnt_d;

  logic [DATA_W-1:0] mem_data;
  logic              hit_any;
  logic [IDX_W-1:0]  hit_way;
  logic              have_free;
  logic [IDX_W-1:0]  free_way;
  logic [IDX_W-1:0]  lru_way;
  logic [IDX_W-1:0]  way;
  logic [IDX_W-1:0]  way_age;

  always_comb begin
    // NOTE: every signal gets a default up front so no path leaves it unassigned (no latches).
    mem_data   = DATA_W'(~addr);
    hit_any    = 1'b0;
    hit_way    = '0;
    have_free  = 1'b0;
    free_way   = '0;
    lru_way    = '0;
    valid_d    = valid_q;
    tag_d      = tag_q;
    data_d     = data_q;
    age_d      = age_q;

    for (int i = 0; i < NUM_LINES; i++) begin
      if (valid_q[i] && (tag_q[i] == addr)) begin
        hit_any = 1'b1;
        hit_way = IDX_W'(i);
      end
      if (age_q[i] == LRU_AGE) lru_way = IDX_W'(i);
    end

    // Scan downwards so the lowest-index invalid way wins.
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        have_free = 1'b1;
        free_way  = IDX_W'(i);
      end
    end

    way     = hit_any ? hit_way : (have_free ? free_way : lru_way);
    way_age = age_q[way];

    for (int i = 0; i < NUM_LINES; i++) begin
      if (IDX_W'(i) == way)         age_d[i] = '0;
      else if (age_q[i] < way_age)  age_d[i] = age_q[i] + IDX_W'(1);
    end

    if (!hit_any) begin
      valid_d[way] = 1'b1;
      tag_d[way]   = addr;
      data_d[way]  = mem_data;
    end

    out_d      = hit_any ? data_q[hit_way] : mem_data;
    hit_d      = hit_any;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit_any && (hit_cnt_q != 8'hFF))   hit_cnt_d  = hit_cnt_q + 8'd1;
    if (!hit_any && (miss_cnt_q != 8'hFF)) miss_cnt_d = miss_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: tag/data storage is reset too, so no X can reach out even if valid logic is later reworked.
      for (int i = 0; i < NUM_LINES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        data_q[i]  <= '0;
        age_q[i]   <= IDX_W'(i);
      end
      out_q      <= '0;
      hit_q      <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking here so every flop samples the pre-edge values computed above.
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
      age_q      <= age_d;
      out_q      <= out_d;
      hit_q      <= hit_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign out      = out_q;
  assign hit      = hit_q;
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_fully_assoc_cache.sv
// Self-checking bench for fully_assoc_cache: vector table for fill/LRU order,
// hand-written sequences for async reset, counter saturation and LRU thrash.
module tb_fully_assoc_cache;

  logic       clk;
  logic       rst;
  logic [7:0] addr;
  logic [7:0] out;
  logic       hit;
  logic [7:0] hit_cnt;
  logic [7:0] miss_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] exp_out;
    logic       exp_hit;
  } vec_t;

  typedef struct {
    logic [7:0] out;
    logic       hit;
    logic [7:0] hc;
    logic [7:0] mc;
  } exp_t;

  exp_t sb_q[$];
  int   m_hits;
  int   m_misses;

  fully_assoc_cache #(.NUM_LINES(4), .ADDR_W(8), .DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .out      (out),
    .hit      (hit),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected counters are tallied here from the expected hit flag.
  task automatic step(input string tag, input logic [7:0] a, input logic [7:0] eo, input logic eh);
    exp_t e;
    if (eh) begin
      if (m_hits < 255) m_hits++;
    end else begin
      if (m_misses < 255) m_misses++;
    end
    e.out = eo;
    e.hit = eh;
    e.hc  = 8'(m_hits);
    e.mc  = 8'(m_misses);
    sb_q.push_back(e);
    addr = a;
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({tag, ".out"},      32'(out),      32'(e.out));
    check({tag, ".hit"},      32'(hit),      32'(e.hit));
    check({tag, ".hit_cnt"},  32'(hit_cnt),  32'(e.hc));
    check({tag, ".miss_cnt"}, 32'(miss_cnt), 32'(e.mc));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst  = 1'b0;
    addr = 8'hA5;
    repeat (2) @(posedge clk);
    #1;
    check("reset.out",      32'(out),      32'h0);
    check("reset.hit",      32'(hit),      32'h0);
    check("reset.hit_cnt",  32'(hit_cnt),  32'h0);
    check("reset.miss_cnt", 32'(miss_cnt), 32'h0);
    @(negedge clk);
    rst      = 1'b1;
    m_hits   = 0;
    m_misses = 0;
    sb_q.delete();
  endtask

  vec_t vecs[$];

  initial begin
    rst      = 1'b0;
    addr     = 8'h00;
    m_hits   = 0;
    m_misses = 0;

    // Cold fill, LRU eviction and eviction order, then re-access of 10.
    vecs = '{
      '{8'd10, 8'hF5, 1'b0}, '{8'd10, 8'hF5, 1'b1},
      '{8'd11, 8'hF4, 1'b0}, '{8'd11, 8'hF4, 1'b1},
      '{8'd12, 8'hF3, 1'b0}, '{8'd12, 8'hF3, 1'b1},
      '{8'd13, 8'hF2, 1'b0}, '{8'd13, 8'hF2, 1'b1},
      '{8'd14, 8'hF1, 1'b0}, '{8'd14, 8'hF1, 1'b1},
      '{8'd12, 8'hF3, 1'b1}, '{8'd12, 8'hF3, 1'b1},
      '{8'd15, 8'hF0, 1'b0}, '{8'd15, 8'hF0, 1'b1},
      '{8'd16, 8'hEF, 1'b0}, '{8'd16, 8'hEF, 1'b1},
      '{8'd17, 8'hEE, 1'b0}, '{8'd17, 8'hEE, 1'b1},
      '{8'd18, 8'hED, 1'b0}, '{8'd18, 8'hED, 1'b1},
      '{8'd19, 8'hEC, 1'b0}, '{8'd19, 8'hEC, 1'b1},
      '{8'd10, 8'hF5, 1'b0}
    };

    apply_reset();

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_out, vecs[i].exp_hit);
      if (i == 7) begin
        check("fill.hit_cnt",  32'(hit_cnt),  32'd4);
        check("fill.miss_cnt", 32'(miss_cnt), 32'd4);
      end
      if (i == 21) begin
        check("order.hit_cnt",  32'(hit_cnt),  32'd12);
        check("order.miss_cnt", 32'(miss_cnt), 32'd10);
      end
    end

    // 19 and 18 are still resident: hits that change nothing but LRU order.
    step("resident19", 8'd19, 8'hEC, 1'b1);
    step("resident18", 8'd18, 8'hED, 1'b1);

    // Asynchronous reset mid-cycle: outputs clear without a clock edge.
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async.out",      32'(out),      32'h0);
    check("async.hit",      32'(hit),      32'h0);
    check("async.hit_cnt",  32'(hit_cnt),  32'h0);
    check("async.miss_cnt", 32'(miss_cnt), 32'h0);
    @(negedge clk);
    rst      = 1'b1;
    m_hits   = 0;
    m_misses = 0;
    sb_q.delete();

    // Reset invalidated every line, so a previously resident address misses.
    step("post_reset19", 8'd19, 8'hEC, 1'b0);
    step("post_reset19b", 8'd19, 8'hEC, 1'b1);

    // Saturation: 300 accesses to one address.
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      step($sformatf("sat%0d", i), 8'h55, 8'hAA, (i != 0));
    end
    check("sat.hit_cnt",  32'(hit_cnt),  32'd255);
    check("sat.miss_cnt", 32'(miss_cnt), 32'd1);

    // Thrash: NUM_LINES+1 distinct addresses round-robin always miss under LRU.
    apply_reset();
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 5; k++) begin
        logic [7:0] a;
        a = 8'(8'h40 + k);
        step($sformatf("thrash%0d_%0d", r, k), a, ~a, 1'b0);
      end
    end
    check("thrash.hit_cnt",  32'(hit_cnt),  32'd0);
    check("thrash.miss_cnt", 32'(miss_cnt), 32'd20);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
